// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide.
// The unit works on operand magnitudes, one radix-2 step per cycle, and
// applies sign correction in a single FIXUP cycle. Divide-by-zero and signed
// overflow are answered directly from IDLE without iterating.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_a_neg, r_b_neg;
  logic [XLEN-1:0]   r_b;        // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] r_acc;      // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   r_result;

  // ---- request decode (valid only in IDLE) ----
  logic            w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;

  assign w_accept = valid_i && (r_state == S_IDLE) && !flush_i;
  // MUL/MULH/MULHSU/DIV/REM treat a as signed; MUL/MULH/DIV/REM treat b as signed
  assign w_a_sgn  = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign w_b_sgn  = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
  assign w_a_neg  = w_a_sgn && operand_a_i[XLEN-1];
  assign w_b_neg  = w_b_sgn && operand_b_i[XLEN-1];
  assign w_a_mag  = w_a_neg ? -operand_a_i : operand_a_i;
  assign w_b_mag  = w_b_neg ? -operand_b_i : operand_b_i;

  assign w_div0    = funct3_i[2] && (operand_b_i == '0);
  assign w_ovf     = funct3_i[2] && !funct3_i[0] &&
                     (operand_a_i == MIN_NEG) && (operand_b_i == '1);
  assign w_special = w_div0 || w_ovf;
  // funct3_i[1] separates remainder ops from quotient ops
  assign w_spec_res = w_div0 ? (funct3_i[1] ? operand_a_i : '1)
                             : (funct3_i[1] ? '0 : MIN_NEG);

  // ---- iteration step ----
  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mul_next, w_div_next;

  // shift-add: add multiplicand into the high half when the current LSB is set
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // restoring divide: shift next dividend bit into the partial remainder
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = w_rem_sh >= {1'b0, r_b};
  // when w_ge holds the true difference is below 2^XLEN, so the wrapped result is exact
  assign w_diff     = w_rem_sh[XLEN-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff,               r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0};

  // ---- sign fixup ----
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_prod = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
  assign w_quo  = (r_a_neg ^ r_b_neg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Select the final result for the latched op
  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and handshake outputs; flush overrides every transition
  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIXUP;
      end
      S_FIXUP: begin
        busy_o = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next  = S_IDLE;
      valid_o = 1'b0;
    end
  end

  // Datapath: latch on accept, iterate in CALC, capture result on entry to DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= funct3_i;
        r_a_neg <= w_a_neg;
        r_b_neg <= w_b_neg;
        r_b     <= w_b_mag;
        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
        r_cnt <= (r_cnt == CNT_W'(XLEN-1)) ? '0 : r_cnt + 1'b1;
      end
      if (w_next == S_DONE)
        r_result <= (r_state == S_IDLE) ? w_spec_res : w_fix_res;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .funct3_i(funct3_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference RV32M semantics in 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request and observe it until the unit is ready again (stimulus only)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output int pulses);
    res = '0; lat = -1; busy_n = 0; pulses = 0;
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = op; operand_a_i = a; operand_b_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; funct3_i = 3'($urandom); operand_a_i = $urandom; operand_b_i = $urandom;
    for (int c = 1; c <= 100; c++) begin
      if (valid_o) begin
        pulses++;
        if (lat < 0) begin lat = c; res = result_o; end
      end
      if (busy_o) busy_n++;
      if (ready_o) break;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset;
    logic [31:0] res; int lat, bn, np;
    repeat (2) @(negedge clk_i);
    total++; if ({ready_o, busy_o, valid_o} !== 3'b100) begin bad++;
      $display("FAIL reset_flags: got %b want 100", {ready_o, busy_o, valid_o}); end
    total++; if (result_o !== 32'h0) begin bad++;
      $display("FAIL reset_result: got %h want 0", result_o); end
    rst_ni = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, res, lat, bn, np);
    total++; if (res !== 32'd15) begin bad++;
      $display("FAIL pre_reset_mul: got %h want f", res); end
    // abort a MULHU mid-CALC with asynchronous reset
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = 3'd3; operand_a_i = '1; operand_b_i = '1;
    @(posedge clk_i);
    @(negedge clk_i); valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({ready_o, busy_o, valid_o} !== 3'b100) begin bad++;
      $display("FAIL async_reset_flags: got %b want 100", {ready_o, busy_o, valid_o}); end
    total++; if (result_o !== 32'h0) begin bad++;
      $display("FAIL async_reset_result: got %h want 0", result_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bn, np);
    total++; if (res !== 32'hFFFF_FFFE) begin bad++;
      $display("FAIL post_reset_mulhu: got %h want fffffffe", res); end
    total++; if (lat !== 34) begin bad++;
      $display("FAIL post_reset_latency: got %0d want 34", lat); end
  endtask

  task automatic test_mul;
    logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] as  [3] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] res; int lat, bn, np;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bn, np);
      total++; if (res !== exp[i]) begin bad++;
        $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]); end
      total++; if (bn !== 34) begin bad++;
        $display("FAIL mul_busy[%0d]: got %0d want 34", i, bn); end
      total++; if (np !== 1) begin bad++;
        $display("FAIL mul_pulses[%0d]: got %0d want 1", i, np); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res; int lat, bn, np;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bn, np);
      total++; if (res !== exp[i]) begin bad++;
        $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]); end
      total++; if (lat !== 34) begin bad++;
        $display("FAIL div_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; int lat, bn, np;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bn, np);
      total++; if (res !== exp[i]) begin bad++;
        $display("FAIL special_result[%0d]: got %h want %h", i, res, exp[i]); end
      total++; if (lat !== 1 || bn !== 1) begin bad++;
        $display("FAIL special_latency[%0d]: got lat=%0d busy=%0d want 1/1", i, lat, bn); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] res; int lat, bn, np, seen;
    run_op(3'd5, 32'd1000, 32'd10, res, lat, bn, np);
    total++; if (res !== 32'd100) begin bad++;
      $display("FAIL flush_setup: got %h want 64", res); end
    seen = 0;
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = 3'd0; operand_a_i = 32'h12345; operand_b_i = 32'h6789;
    @(posedge clk_i);
    @(negedge clk_i); valid_i = 1'b0;
    repeat (9) begin @(negedge clk_i); if (valid_o) seen++; end
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b0;
    total++; if ({ready_o, busy_o} !== 2'b10) begin bad++;
      $display("FAIL flush_idle: got ready/busy %b want 10", {ready_o, busy_o}); end
    total++; if (result_o !== 32'd100) begin bad++;
      $display("FAIL flush_result_held: got %h want 64", result_o); end
    repeat (40) begin @(negedge clk_i); if (valid_o) seen++; end
    total++; if (seen !== 0) begin bad++;
      $display("FAIL flush_no_valid: got %0d pulses want 0", seen); end
    // valid together with flush in IDLE must not start an op
    valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0;
    @(posedge clk_i);
    @(negedge clk_i); valid_i = 1'b0; flush_i = 1'b0;
    total++; if ({ready_o, busy_o} !== 2'b10) begin bad++;
      $display("FAIL flush_blocks_accept: got ready/busy %b want 10", {ready_o, busy_o}); end
    run_op(3'd0, 32'd3, 32'd4, res, lat, bn, np);
    total++; if (res !== 32'd12) begin bad++;
      $display("FAIL flush_then_mul: got %h want c", res); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r [2];
    int np, idle_c;
    np = 0; idle_c = 0; r[0] = '0; r[1] = '0;
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = 3'd5; operand_a_i = 32'd100; operand_b_i = 32'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    funct3_i = 3'd0; operand_a_i = 32'd6; operand_b_i = 32'd7;
    for (int c = 1; c <= 200; c++) begin
      if (valid_o) begin
        if (np < 2) r[np] = result_o;
        np++;
      end
      if (ready_o && valid_i) idle_c = c;
      if (np >= 2 && ready_o) break;
      @(negedge clk_i);
      if (idle_c != 0) valid_i = 1'b0;
    end
    repeat (5) begin @(negedge clk_i); if (valid_o) np++; end
    total++; if (np !== 2) begin bad++;
      $display("FAIL b2b_pulses: got %0d want 2", np); end
    total++; if (idle_c !== 35) begin bad++;
      $display("FAIL b2b_second_accept: got cycle %0d want 35", idle_c); end
    total++; if (r[0] !== 32'd14 || r[1] !== 32'd42) begin bad++;
      $display("FAIL b2b_results: got %h,%h want e,2a", r[0], r[1]); end
  endtask

  task automatic test_random;
    logic [31:0] res, a, b, v; logic [2:0] op; int lat, bn, np;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: v = 32'h0;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        if (k == 0) a = v; else b = v;
      end
      run_op(op, a, b, res, lat, bn, np);
      total++; if (res !== ref_op(op, a, b) || lat !== ref_lat(op, a, b)) begin bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 i, op, a, b, res, lat, ref_op(op, a, b), ref_lat(op, a, b)); end
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_flush;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit. It sits downstream of alu_controller, beside the ALU, and executes the eight M-extension ops selected by funct3 when the decoder flags an M instruction (funct7 = 0000001). While an op is in flight it holds busy_o high so the core can stall the PC and register write-back. It produces one result per accepted request.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  request strobe; an M instruction is present
funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  input  XLEN  rs1 value
operand_b_i  input  XLEN  rs2 value
flush_i  input  1  abort the current op, no result produced
ready_o  output  1  high only in IDLE; request accepted on edge where valid_i && ready_o && !flush_i
busy_o  output  1  high in CALC, FIXUP, DONE; core stall request
valid_o  output  1  one-cycle pulse, result_o valid
result_o  output  XLEN  result; held until next accept

Behaviour:
- Reset (async, rst_ni low): state=IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, counter=0, all datapath registers=0. Reset mid-operation aborts immediately. After release the unit is ready in IDLE.
- FSM states:
  - IDLE: on accept, latch the op and operand magnitudes/signs.
    - DIV/DIVU/REM/REMU with b==0 go to DONE.
    - DIV/REM with a==-2^(XLEN-1) and b==-1 (overflow) go to DONE.
    - Everything else goes to CALC with counter=0.
  - CALC: one radix-2 step per cycle on magnitudes.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring, 1 quotient bit per cycle.
    - After XLEN steps (counter==XLEN-1), go to FIXUP.
  - FIXUP: apply sign correction and select the result, then go to DONE.
  - DONE: valid_o=1 for this cycle only, then go to IDLE. ready_o=0 here, so valid_i in DONE is accepted in the following IDLE cycle.
- Latency:
  - Normal op: valid_o is high in cycle XLEN+2 after the accepting edge (34 for XLEN=32).
  - Special cases (divide-by-zero, overflow): valid_o is high in the cycle immediately after the accepting edge.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Results:
  - MUL: low XLEN bits of the product. MULH/MULHSU/MULHU: high XLEN bits.
  - Product is negated in FIXUP if exactly one effective operand is negative.
  - Quotient is negated if the dividend and divisor signs differ (signed ops only). It truncates toward zero.
  - Remainder takes the dividend's sign.
- Special results:
  - Divide by zero: quotient all ones; remainder = a.
  - Overflow: quotient = -2^(XLEN-1); remainder = 0.
- result_o updates only when entering DONE and holds its value through IDLE.
- flush_i has priority over everything except reset.
  - In any state, the next state is IDLE with the counter cleared and valid_o=0.
  - result_o keeps its old value.
  - valid_i with flush_i in IDLE is not accepted.
- valid_i while busy_o=1 is ignored; the operand inputs are don't-care after accept.
- Counter never wraps: CALC exits exactly at XLEN-1.

Test Plan:
- Reset: assert rst_ni=0 mid-CALC -> outputs drop to 0 asynchronously, ready_o=1. Release, then MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, valid_o at cycle 34.
- Multiply signedness:
  - MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB.
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - Each with busy_o high for 34 cycles and a single valid_o pulse.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100%7 -> 2.
- Special cases, each with valid_o in cycle 1 after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Flush: flush_i at cycle 10 of CALC -> IDLE next edge, no valid_o, result_o unchanged. A new MUL 3*4 then returns 12.
- Back-to-back: hold valid_i high across two requests -> second accepted in the IDLE cycle after DONE. valid_i during busy is ignored, giving exactly two valid_o pulses.
